// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: registered one-hot grants, a park cycle between
// owners, and a hold timeout that preempts an owner while others are waiting.
module rr_grant_sched #(
  parameter int N        = 4,
  parameter int IW       = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          rel,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] owner,
  output logic          busy,
  output logic          preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, PARK} state_t;

  localparam logic [7:0]    HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  state_t        state, state_next;
  logic [IW-1:0] ptr, ptr_next;
  logic [7:0]    cnt, cnt_next;
  logic [N-1:0]  gnt_next;
  logic [IW-1:0] owner_next;
  logic          busy_next, preempt_next;
  logic [IW-1:0] winner;
  logic          found;
  logic          rel_end, timeout;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_w;
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx   = (int'(ptr) + i) % N;
      idx_w = IW'(idx);
      if (!found && req[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  assign rel_end = rel || !req[owner];
  assign timeout = (cnt == HOLD_LAST) && ((req & ~gnt) != '0);

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    cnt_next     = cnt;
    gnt_next     = gnt;
    owner_next   = owner;
    busy_next    = busy;
    preempt_next = preempt;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          gnt_next   = N'(1) << winner;
          owner_next = winner;
          cnt_next   = 8'd0;
          busy_next  = 1'b1;
        end
      end
      GRANT: begin
        // A release on the same edge as a timeout is not a preemption.
        if (rel_end || timeout) begin
          state_next   = PARK;
          gnt_next     = '0;
          busy_next    = 1'b0;
          ptr_next     = (owner == LAST_IDX) ? '0 : owner + 1'b1;
          preempt_next = !rel_end;
        end else if (cnt != HOLD_LAST) begin
          cnt_next = cnt + 8'd1;
        end
      end
      PARK: begin
        state_next   = IDLE;
        preempt_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= 8'd0;
      gnt     <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      preempt <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      cnt     <= cnt_next;
      gnt     <= gnt_next;
      owner   <= owner_next;
      busy    <= busy_next;
      preempt <= preempt_next;
    end
  end

endmodule
